// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for a 5-stage pipeline. It detects ID-stage RAW
// hazards against the EXE and MEM destinations, squashes wrong-path
// instructions on a taken branch, and freezes the whole pipeline while the
// MEM stage waits on the multi-cycle SRAM.
//
// Ports
//   clk, rst                 pipeline clock (rising edge), async active-high reset
//   forward_en               forwarding active: only load-use hazards stall
//   id_src1/id_src2/id_two_src   ID-stage source operands
//   exe_dst/exe_wb_en/exe_mem_read  ID/EX destination info
//   mem_dst/mem_wb_en        EX/MEM destination info
//   branch_taken             EXE resolved a taken branch
//   mem_req, sram_ready      MEM-stage access request / SRAM completion pulse
//   pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze  pipeline controls
//   sram_start               registered 1-cycle SRAM start pulse
//   mem_timeout              sticky: an access was aborted on timeout
//   stall_cycles             saturating count of cycles with pc_freeze=1
//
// state  | meaning
// S_IDLE | no access in flight; a mem_req freezes at once and launches one
// S_WAIT | SRAM busy; pipeline frozen until sram_ready or timeout
// S_DONE | one unfrozen cycle so EX/MEM advances past the finished request

module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic [4:0]        id_src1,
    input  logic [4:0]        id_src2,
    input  logic              id_two_src,
    input  logic [4:0]        exe_dst,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [4:0]        mem_dst,
    input  logic              mem_wb_en,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              sram_ready,
    output logic              pc_freeze,
    output logic              ifid_freeze,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              pipe_freeze,
    output logic              sram_start,
    output logic              mem_timeout,
    output logic [STAT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LP_WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_sram_start;
    logic               r_mem_timeout;
    logic [STAT_W-1:0]  r_stall_cycles;

    logic               w_match_exe;
    logic               w_match_mem;
    logic               w_hz;
    logic               w_mem_freeze;
    logic               w_start_nxt;
    logic               w_timeout_set;
    logic               w_pc_freeze;

    // Register 0 is hard-wired zero and never creates a dependency.
    function automatic logic f_match(input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic two);
        return (d != 5'd0) && ((d == s1) || (two && (d == s2)));
    endfunction

    always_comb begin
        w_match_exe = f_match(exe_dst, id_src1, id_src2, id_two_src);
        w_match_mem = f_match(mem_dst, id_src1, id_src2, id_two_src);
        if (forward_en)
            w_hz = exe_mem_read & w_match_exe;
        else
            w_hz = (exe_wb_en & w_match_exe) | (mem_wb_en & w_match_mem);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mem_freeze  = 1'b0;
        w_start_nxt   = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mem_freeze = mem_req;
                if (mem_req) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_mem_freeze = 1'b1;
                if (sram_ready) begin
                    w_state_nxt = S_DONE;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_sram_start   <= 1'b0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sram_start <= w_start_nxt;
            // Counter is zero on entry to WAIT and counts WAIT cycles only.
            if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_timeout_set)
                r_mem_timeout <= 1'b1;
            if (w_pc_freeze && !(&r_stall_cycles))
                r_stall_cycles <= r_stall_cycles + STAT_W'(1);
        end
    end

    // A memory freeze overrides hazards and branches; a branch beats a hazard.
    assign w_pc_freeze  = w_mem_freeze | (w_hz & ~branch_taken);
    assign pc_freeze    = w_pc_freeze;
    assign ifid_freeze  = w_pc_freeze;
    assign ifid_flush   = branch_taken & ~w_mem_freeze;
    assign idex_flush   = ~w_mem_freeze & (branch_taken | w_hz);
    assign pipe_freeze  = w_mem_freeze;
    assign sram_start   = r_sram_start;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl. Two instances share all inputs:
// dut_a uses a short timeout and narrow counters, dut_b the defaults.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic       branch_taken, mem_req, sram_ready;
    logic [4:0] id_src1, id_src2, exe_dst, mem_dst;

    logic        a_pc, a_ifz, a_iff, a_idf, a_pipe, a_start, a_to;
    logic [3:0]  a_stall;
    logic        b_pc, b_ifz, b_iff, b_idf, b_pipe, b_start, b_to;
    logic [15:0] b_stall;

    int checks   = 0;
    int failures = 0;

    // Reference model state, per instance (0 = dut_a, 1 = dut_b)
    int tov[2]  = '{4, 255};
    int smax[2] = '{15, 65535};
    bit m_busy[2], m_gap[2], m_start[2], m_to[2];
    int m_cnt[2], m_stall[2];
    bit e_pc[2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(3), .STAT_W(4)) dut_a (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_src1(id_src1),
        .id_src2(id_src2), .id_two_src(id_two_src), .exe_dst(exe_dst),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dst(mem_dst),
        .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .pc_freeze(a_pc), .ifid_freeze(a_ifz),
        .ifid_flush(a_iff), .idex_flush(a_idf), .pipe_freeze(a_pipe),
        .sram_start(a_start), .mem_timeout(a_to), .stall_cycles(a_stall));

    pipeline_hazard_ctrl dut_b (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_src1(id_src1),
        .id_src2(id_src2), .id_two_src(id_two_src), .exe_dst(exe_dst),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dst(mem_dst),
        .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .pc_freeze(b_pc), .ifid_freeze(b_ifz),
        .ifid_flush(b_iff), .idex_flush(b_idf), .pipe_freeze(b_pipe),
        .sram_start(b_start), .mem_timeout(b_to), .stall_cycles(b_stall));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A source operand is unavailable if an older in-flight instruction will
    // write it and that value cannot be forwarded in time.
    function automatic bit model_hazard();
        bit         hz;
        logic [4:0] srcs[$];
        hz = 0;
        srcs.push_back(id_src1);
        if (id_two_src) srcs.push_back(id_src2);
        foreach (srcs[i]) begin
            if (srcs[i] != 0) begin
                if (forward_en) begin
                    if (exe_mem_read && exe_dst == srcs[i]) hz = 1;
                end else begin
                    if (exe_wb_en && exe_dst == srcs[i]) hz = 1;
                    if (mem_wb_en && mem_dst == srcs[i]) hz = 1;
                end
            end
        end
        return hz;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_gap[k] = 0; m_start[k] = 0; m_to[k] = 0;
            m_cnt[k] = 0; m_stall[k] = 0;
        end
    endtask

    // Compare every output of both instances against the model (mid-cycle).
    task automatic step();
        bit hz, mf;
        bit e_iff[2], e_idf[2], e_pipe[2];
        #2;
        hz = model_hazard();
        for (int k = 0; k < 2; k++) begin
            mf = m_busy[k] || (!m_gap[k] && mem_req);
            e_pc[k]   = mf || (hz && !branch_taken);
            e_iff[k]  = branch_taken && !mf;
            e_idf[k]  = !mf && (branch_taken || hz);
            e_pipe[k] = mf;
        end
        chk("a_pc_freeze",   a_pc,    e_pc[0]);
        chk("a_ifid_freeze", a_ifz,   e_pc[0]);
        chk("a_ifid_flush",  a_iff,   e_iff[0]);
        chk("a_idex_flush",  a_idf,   e_idf[0]);
        chk("a_pipe_freeze", a_pipe,  e_pipe[0]);
        chk("a_sram_start",  a_start, m_start[0]);
        chk("a_mem_timeout", a_to,    m_to[0]);
        chk("a_stall",       a_stall, m_stall[0]);
        chk("b_pc_freeze",   b_pc,    e_pc[1]);
        chk("b_ifid_freeze", b_ifz,   e_pc[1]);
        chk("b_ifid_flush",  b_iff,   e_iff[1]);
        chk("b_idex_flush",  b_idf,   e_idf[1]);
        chk("b_pipe_freeze", b_pipe,  e_pipe[1]);
        chk("b_sram_start",  b_start, m_start[1]);
        chk("b_mem_timeout", b_to,    m_to[1]);
        chk("b_stall",       b_stall, m_stall[1]);
    endtask

    // Advance one clock; model consumes the inputs that were present at the edge.
    task automatic adv();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (e_pc[k] && m_stall[k] < smax[k]) m_stall[k]++;
            m_start[k] = 0;
            if (m_busy[k]) begin
                if (sram_ready) begin
                    m_busy[k] = 0; m_gap[k] = 1;
                end else if (m_cnt[k] == tov[k] - 1) begin
                    m_to[k] = 1; m_busy[k] = 0; m_gap[k] = 1;
                end else begin
                    m_cnt[k]++;
                end
            end else if (m_gap[k]) begin
                m_gap[k] = 0;
            end else if (mem_req) begin
                m_busy[k] = 1; m_cnt[k] = 0; m_start[k] = 1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        forward_en = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0;
        mem_wb_en = 0; branch_taken = 0; mem_req = 0; sram_ready = 0;
        id_src1 = 0; id_src2 = 0; exe_dst = 0; mem_dst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();

        // Reset state
        step();
        chk("rst_pc", a_pc, 0);
        chk("rst_stall", b_stall, 0);
        @(posedge clk); #1;
        rst = 0;

        // Non-forwarding RAW against EXE, then register 0
        exe_wb_en = 1; exe_dst = 5; id_src1 = 5;
        step();
        chk("t1_pc", a_pc, 1); chk("t1_idex", b_idf, 1); chk("t1_pipe", a_pipe, 0);
        adv();
        exe_dst = 0; id_src1 = 0;
        step();
        chk("t1_r0_pc", b_pc, 0); chk("t1_r0_idex", a_idf, 0);
        adv();

        // Forwarding: only load-use on src2 stalls
        clear_inputs();
        forward_en = 1; exe_dst = 7; id_src2 = 7; id_two_src = 1; exe_wb_en = 1;
        step(); chk("t2_alu_pc", a_pc, 0); adv();
        exe_mem_read = 1;
        step(); chk("t2_load_pc", a_pc, 1); adv();
        id_two_src = 0;
        step(); chk("t2_one_src_pc", b_pc, 0); adv();
        mem_wb_en = 1; mem_dst = 9; id_src1 = 9;
        step(); chk("t2_mem_ignored", b_pc, 0); adv();

        // SRAM access: dut_b gets ready after 4 cycles, dut_a times out first
        clear_inputs();
        mem_req = 1;
        step(); chk("t3_idle_freeze", b_pipe, 1); chk("t3_no_start", b_start, 0); adv();
        for (int i = 0; i < 5; i++) begin
            sram_ready = (i == 4);
            step();
            chk("t3_start_pulse", b_start, (i == 0));
            chk("t3_wait_freeze", b_pipe, 1);
            adv();
        end
        sram_ready = 0;
        step(); chk("t3_done_unfrozen", b_pipe, 0); chk("t4_timeout", a_to, 1); adv();
        mem_req = 0;
        step(); chk("t3_back_idle", b_pipe, 0); adv();
        for (int i = 0; i < 8; i++) begin step(); adv(); end
        step(); chk("t4_timeout_sticky", a_to, 1); chk("t3_no_timeout_b", b_to, 0); adv();

        // Branch with load-use hazard, then branch during an SRAM wait
        forward_en = 1; exe_mem_read = 1; exe_dst = 3; id_src1 = 3; branch_taken = 1;
        step();
        chk("t5_iff", a_iff, 1); chk("t5_idf", a_idf, 1); chk("t5_pc", a_pc, 0);
        adv();
        mem_req = 1;
        step(); adv();
        step();
        chk("t5_wait_pc", b_pc, 1); chk("t5_wait_pipe", b_pipe, 1);
        chk("t5_wait_iff", b_iff, 0); chk("t5_wait_idf", b_idf, 0);
        sram_ready = 1;
        adv();
        clear_inputs();
        for (int i = 0; i < 8; i++) begin step(); adv(); end

        // Reset in the middle of WAIT
        mem_req = 1;
        step(); adv();
        step(); adv();
        rst = 1;
        #1;
        chk("t6_start_a", a_start, 0); chk("t6_start_b", b_start, 0);
        chk("t6_to_a", a_to, 0); chk("t6_stall_a", a_stall, 0); chk("t6_stall_b", b_stall, 0);
        model_reset();
        mem_req = 0;
        @(posedge clk); #1;
        rst = 0;
        mem_req = 1;
        step(); adv();
        step(); chk("t6_fresh_start", b_start, 1); chk("t6_fresh_start_a", a_start, 1); adv();
        clear_inputs();
        for (int i = 0; i < 8; i++) begin step(); adv(); end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            forward_en   = 1'($urandom_range(0, 1));
            id_src1      = 5'($urandom_range(0, 3));
            id_src2      = 5'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            exe_dst      = 5'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_read = 1'($urandom_range(0, 1));
            mem_dst      = 5'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 3) == 0);
            mem_req      = ($urandom_range(0, 2) == 0);
            sram_ready   = ($urandom_range(0, 3) == 0);
            step();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
